// File: rtl/arkhe_pkg.sv
// Shared constants and types for the Arkhe handover scheduler.
// Q16.16 state/coupling values; fidelities are unsigned Q0.16.
package arkhe_pkg;

  localparam logic [31:0] ONE     = 32'h0001_0000;
  localparam logic [31:0] PHI     = 32'h0000_9E37;
  localparam logic [15:0] DEF_FID = 16'hF000;

  localparam int unsigned RES_W     = 32;
  localparam int unsigned RES_SRC_W = 4;
  localparam int unsigned RES_TID_W = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fsm_state_e;

  typedef struct packed {
    logic [RES_W-1:0]     coupling;
    logic [RES_SRC_W-1:0] src;
    logic [RES_TID_W-1:0] target;
  } handover_res_t;

endpackage

// File: rtl/arkhe_rr_arbiter.sv
// Round-robin arbiter: searches requests starting at a rotating pointer and issues a
// one-hot grant; the pointer moves past the winner only when a grant is issued.
module arkhe_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IDX_W'((32'(r_ptr) + k) % N);
      if (!w_any && i_req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_any && i_advance) begin
      o_grant[w_win] = 1'b1;
    end
  end

  assign o_idx = w_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any && i_advance) begin
      r_ptr <= (w_win == IDX_W'(N - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/arkhe_handover_scheduler.sv
// Time-shares one Q16.16 handover multiplier among N_REQ sources through a 2-stage pipe,
// with a runtime fidelity table and a quiesce FSM that drains the pipe before halting.
module arkhe_handover_scheduler
  import arkhe_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TID_W   = 4,
  parameter logic [15:0] DEF_FID = arkhe_pkg::DEF_FID,
  localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]   i_req_state,
  input  logic [N_REQ*TID_W-1:0]   i_req_target,
  input  logic                     i_cfg_we,
  input  logic [IDX_W-1:0]         i_cfg_idx,
  input  logic [15:0]              i_cfg_fid,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [WIDTH-1:0]         o_out_coupling,
  output logic [IDX_W-1:0]         o_out_src,
  output logic [TID_W-1:0]         o_out_target,
  input  logic                     i_quiesce,
  output logic                     o_idle
);

  fsm_state_e       r_state;
  fsm_state_e       w_state_nxt;
  logic             w_run_grant;
  logic             w_grant_en;
  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_win;
  logic             w_accept;
  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_pipe_empty;

  logic [15:0]      r_fid [N_REQ];

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_state;
  logic [TID_W-1:0] r_s1_target;
  logic [IDX_W-1:0] r_s1_src;
  logic [15:0]      r_s1_fid;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_coupling;
  logic [TID_W-1:0] r_s2_target;
  logic [IDX_W-1:0] r_s2_src;

  logic [WIDTH-1:0] w_coupling;

  // Exact signed product fits in WIDTH+17 bits; keeping bits [WIDTH+15:16] is floor(>>>16).
  function automatic logic [WIDTH-1:0] fx_scale(input logic [WIDTH-1:0] state,
                                                input logic [15:0] fid);
    logic signed [WIDTH+16:0] prod;
    prod = $signed({{17{state[WIDTH-1]}}, state}) * $signed({{(WIDTH + 1){1'b0}}, fid});
    return prod[WIDTH+15:16];
  endfunction

  assign w_coupling   = fx_scale(r_s1_state, r_s1_fid);
  assign w_s2_adv     = !r_s2_valid || i_out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign w_pipe_empty = !r_s1_valid && !r_s2_valid;
  assign w_grant_en   = w_run_grant && w_s1_adv;
  assign w_accept     = |w_grant;

  arkhe_rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req_valid),
    .i_advance (w_grant_en),
    .o_grant   (w_grant),
    .o_idx     (w_win)
  );

  assign o_req_ready = w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (i_quiesce) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!i_quiesce) w_state_nxt = RUN;
        else if (w_pipe_empty) w_state_nxt = HALTED;
      end
      HALTED: begin
        if (!i_quiesce) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Grants stop in the very cycle quiesce rises, and while reset is held.
  always_comb begin
    w_run_grant = 1'b0;
    o_idle      = 1'b0;
    case (r_state)
      RUN:     w_run_grant = !i_quiesce && !rst;
      HALTED:  o_idle = 1'b1;
      default: ;
    endcase
  end

  // A write landing on the grant edge is not seen by that grant: S1 samples the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) r_fid[i] <= DEF_FID;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i_cfg_we && (i_cfg_idx == IDX_W'(i))) r_fid[i] <= i_cfg_fid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_state  <= '0;
      r_s1_target <= '0;
      r_s1_src    <= '0;
      r_s1_fid    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_state  <= i_req_state[w_win*WIDTH +: WIDTH];
        r_s1_target <= i_req_target[w_win*TID_W +: TID_W];
        r_s1_src    <= w_win;
        r_s1_fid    <= r_fid[w_win];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_coupling <= '0;
      r_s2_target   <= '0;
      r_s2_src      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_coupling <= w_coupling;
        r_s2_target   <= r_s1_target;
        r_s2_src      <= r_s1_src;
      end
    end
  end

  assign o_out_valid    = r_s2_valid;
  assign o_out_coupling = r_s2_coupling;
  assign o_out_src      = r_s2_src;
  assign o_out_target   = r_s2_target;

endmodule

// File: tb/tb_arkhe_handover_scheduler.sv
// Directed and randomized bench for arkhe_handover_scheduler against a queue-based model
// of the pipe (at most two items, visible two cycles after the grant cycle).
module tb_arkhe_handover_scheduler;
  import arkhe_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
  localparam int unsigned T = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_state;
  logic [N*T-1:0] req_target;
  logic           cfg_we;
  logic [1:0]     cfg_idx;
  logic [15:0]    cfg_fid;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_coupling;
  logic [1:0]     out_src;
  logic [T-1:0]   out_target;
  logic           quiesce;
  logic           idle;

  always #5 clk = ~clk;

  arkhe_handover_scheduler #(
    .N_REQ   (N),
    .WIDTH   (W),
    .TID_W   (T),
    .DEF_FID (16'hF000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_state    (req_state),
    .i_req_target   (req_target),
    .i_cfg_we       (cfg_we),
    .i_cfg_idx      (cfg_idx),
    .i_cfg_fid      (cfg_fid),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_coupling (out_coupling),
    .o_out_src      (out_src),
    .o_out_target   (out_target),
    .i_quiesce      (quiesce),
    .o_idle         (idle)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    handover_res_t r;
    int            acc;
  } item_t;

  item_t          mq[$];
  logic [15:0]    m_fid [N];
  int             m_ptr;
  int             cyc = 0;
  fsm_state_e     m_st;
  logic [N*W-1:0] s_st;
  logic [N*T-1:0] s_tg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] couple(input logic [31:0] s, input logic [15:0] f);
    longint p;
    p = longint'($signed(s)) * longint'(f);
    p = p >>> 16;
    return p[31:0];
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ptr = 0;
    m_st  = RUN;
    for (int i = 0; i < N; i++) m_fid[i] = DEF_FID;
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic ordy, input logic q,
                      input logic we, input logic [1:0] idx, input logic [15:0] fid);
    logic          head_vis;
    logic          cap;
    logic          empty_now;
    int            win;
    logic [N-1:0]  exp_rdy;
    handover_res_t nr;
    item_t         it;
    @(posedge clk);
    #1;
    req_valid  = v;
    req_state  = s_st;
    req_target = s_tg;
    out_ready  = ordy;
    quiesce    = q;
    cfg_we     = we;
    cfg_idx    = idx;
    cfg_fid    = fid;
    @(negedge clk);
    head_vis = (mq.size() > 0) && (cyc >= mq[0].acc + 2);
    cap      = (mq.size() < 2) || (head_vis && ordy);
    win      = -1;
    if (m_st == RUN && !q && cap) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("out_valid", out_valid, head_vis);
    if (head_vis) begin
      chk("out_coupling", out_coupling, mq[0].r.coupling);
      chk("out_src", out_src, mq[0].r.src);
      chk("out_target", out_target, mq[0].r.target);
    end
    chk("idle", idle, m_st == HALTED);
    empty_now = (mq.size() == 0);
    case (m_st)
      RUN:     if (q) m_st = DRAIN;
      DRAIN:   if (!q) m_st = RUN; else if (empty_now) m_st = HALTED;
      default: if (!q) m_st = RUN;
    endcase
    if (head_vis && ordy) void'(mq.pop_front());
    if (win >= 0) begin
      nr.coupling = couple(s_st[win*W +: W], m_fid[win]);
      nr.src      = 4'(win);
      nr.target   = s_tg[win*T +: T];
      it.r        = nr;
      it.acc      = cyc;
      mq.push_back(it);
      m_ptr = (win + 1) % N;
    end
    if (we) m_fid[idx] = fid;
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_coupling", out_coupling, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_idle", idle, 0);
    m_reset();
    req_valid = '0;
    cfg_we    = 1'b0;
    quiesce   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};
    rst        = 1'b1;
    req_valid  = '0;
    req_state  = '0;
    req_target = '0;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_fid    = '0;
    out_ready  = 1'b0;
    quiesce    = 1'b0;
    s_st       = '0;
    s_tg       = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_req_ready", req_ready, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_idle", idle, 0);
    rst = 1'b0;

    // Single request: 1.0 * F000 on source 0 toward target 3.
    s_st = {32'h0, 32'h0, 32'h0, ONE};
    s_tg = {4'h0, 4'h0, 4'h0, 4'h3};
    step(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("single_valid", out_valid, 1);
    chk("single_coupling", out_coupling, 32'h0000_F000);
    chk("single_src", out_src, 0);
    chk("single_target", out_target, 3);

    // Negative state on source 1.
    s_st = {32'h0, 32'h0, 32'hFFFF_0000, 32'h0};
    s_tg = {4'h0, 4'h0, 4'h9, 4'h0};
    step(4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("neg_coupling", out_coupling, 32'hFFFF_1000);

    // Config write racing a grant of the same index.
    s_st = {32'h0, ONE, 32'h0, 32'h0};
    s_tg = {4'h0, 4'h5, 4'h0, 4'h0};
    step(4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 16'h8000);
    step(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("race_old_fid", out_coupling, 32'h0000_F000);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("race_new_fid", out_coupling, 32'h0000_8000);

    // Fairness, starting from a mid-stream reset with every request held high.
    s_st = {ONE, ONE, ONE, ONE};
    s_tg = {4'h4, 4'h3, 4'h2, 4'h1};
    step(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
      chk("fair_order", req_ready, 4'b0001 << ord[i]);
    end
    step(4'b1101, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("fair_skip", req_ready, 4'b0100);
    step(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("fair_next", req_ready, 4'b1000);

    // Back-pressure with all requests active.
    s_st = {32'h0003_0000, 32'hFFFE_8000, 32'h0000_4000, 32'h7FFF_FFFF};
    repeat (3) step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_out_held", out_valid, 1);
    repeat (6) step(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);

    // Quiesce with the pipe full, then resume.
    for (int i = 0; i < 10 && m_st != HALTED; i++) begin
      step(4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
    end
    step(4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
    chk("quiesce_idle", idle, 1);
    chk("quiesce_no_ready", req_ready, 0);
    step(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    step(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("resume_grant", |req_ready, 1);
    chk("resume_idle", idle, 0);

    // Randomized traffic with back-pressure, config writes, quiesce windows and a reset.
    for (int i = 0; i < 300; i++) begin
      logic q;
      s_st = {$urandom, $urandom, $urandom, $urandom};
      s_tg = 16'($urandom);
      q    = ((i / 40) % 3 == 2) ? ($urandom_range(7) != 0) : 1'b0;
      if (i == 150) do_reset();
      step(4'($urandom), $urandom_range(3) != 0, q, $urandom_range(5) == 0,
           2'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
